// File: rtl/sev_seg_scanner.sv
// sev_seg_scanner: multiplexed seven-segment driver for common-anode displays.
// Scans NUM_DIGITS digits, each for 2^SLOT_LOG2 clocks, with PWM brightness.
// Display data is double-buffered: a load fills the pending buffer, and the
// active buffer changes only at the frame boundary (idx wraps to 0).
//
// Optional feature macro: SEV_SEG_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits without a decimal point are blanked
//   (digit 0 is never blanked). Undefined: zeros are shown normally.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   digits_in    hex value per digit, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in        decimal point request per digit (1 = lit)
//   en_in        digit enable per digit (1 = shown)
//   load         one-cycle strobe capturing digits_in/dp_in/en_in
//   brightness   PWM duty, 0 = dark, sampled continuously
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   an           anodes, active-low, at most one low
//   frame_start  pulse in the cycle an first reflects digit 0
//   updated      pulse when new data is committed to the active buffer
`timescale 1ns/1ps
module sev_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SLOT_LOG2  = 17,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    updated
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [SLOT_LOG2-1:0]    tick_q, tick_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;
  logic                    updated_q, updated_d;

  logic                    slot_end, boundary, lit;
  logic [3:0]              cur_digit;
  logic [BRIGHT_W-1:0]     top;
  logic [NUM_DIGITS-1:0]   en_eff;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign slot_end = &tick_q;
  assign boundary = slot_end && (idx_q == LastIdx);

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; blank zeros until the first
  // digit that is nonzero or carries a decimal point.
  logic leading;
  always_comb begin
    en_eff  = act_en_q;
    leading = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (leading && (act_dig_q[4*i +: 4] == 4'h0) && !act_dp_q[i]) begin
        en_eff[i] = 1'b0;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign en_eff = act_en_q;
`endif

  // Scan counters and buffer management.
  always_comb begin
    tick_d       = tick_q + 1'b1;
    idx_d        = idx_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    updated_d    = 1'b0;
    if (slot_end) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_en_d  = en_in;
    end
    if (boundary && load) begin
      // Fresh inputs bypass the pending buffer so they show this frame.
      act_dig_d    = digits_in;
      act_dp_d     = dp_in;
      act_en_d     = en_in;
      pend_valid_d = 1'b0;
      updated_d    = 1'b1;
    end else if (load) begin
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_dp_d     = pend_dp_q;
      act_en_d     = pend_en_q;
      pend_valid_d = 1'b0;
      updated_d    = 1'b1;
    end
  end

  // Output decode, registered one cycle after the scan state.
  always_comb begin
    cur_digit     = act_dig_q[{idx_q, 2'b00} +: 4];
    top           = tick_q[SLOT_LOG2-1 -: BRIGHT_W];
    lit           = en_eff[idx_q] && (top < brightness);
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    frame_start_d = (idx_q == '0) && (tick_q == '0);
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex7(cur_digit);
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q        <= '0;
      idx_q         <= '0;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_valid_q  <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
      updated_q     <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_valid_q  <= pend_valid_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
      updated_q     <= updated_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign updated     = updated_q;

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Testbench for sev_seg_scanner (4 digits, 16-cycle slots, 2-bit brightness).
// Expected frame images are queued when a load is driven and popped when the
// DUT starts the frame that should show them.
`timescale 1ns/1ps
module tb_sev_seg_scanner;
  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in, en_in;
  logic          load;
  logic [B-1:0]  brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_start, updated;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  en;
  } img_t;

  img_t        exp_q[$];
  logic [11:0] fbuf[64];
  int          tests = 0;
  int          fails = 0;
  int          upd_cnt = 0;
  int          onehot_bad = 0;

  sev_seg_scanner #(.NUM_DIGITS(N), .SLOT_LOG2(S), .BRIGHT_W(B)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .brightness(brightness), .seg(seg), .dp(dp), .an(an),
    .frame_start(frame_start), .updated(updated)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (updated) upd_cnt++;
    if ($countones(~an) > 1) onehot_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tbl[16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  // Expected {an, seg, dp} at sample k (0..63) of a frame.
  function automatic logic [11:0] expect_out(input img_t im, input logic [1:0] br, input int k);
    int d, t;
    logic [3:0] en;
    d  = k / 16;
    t  = k % 16;
    en = im.en;
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && im.dig[4*i +: 4] == 4'h0 && !im.dp[i]) en[i] = 1'b0;
        else lead = 1'b0;
      end
    end
`endif
    if (en[d] && (t / 4) < int'(br))
      return {~(4'b0001 << d), hex7(im.dig[4*d +: 4]), ~im.dp[d]};
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    en_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    digits_in = d;
    dp_in = p;
    en_in = e;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Records the current sample plus the following 63 samples.
  task automatic capture_frame();
    fbuf[0] = {an, seg, dp};
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      fbuf[k] = {an, seg, dp};
    end
  endtask

  task automatic test_reset();
    int dark_bad, fs_cnt, fs_first, fs_last, fs_gap_bad, u0;
    brightness = 2'd3;
    do_reset();
    tests++; if (an !== 4'hF) begin fails++; $display("FAIL reset_an: got %h want F", an); end
    tests++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7F", seg); end
    tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    tests++; if (updated !== 1'b0) begin fails++; $display("FAIL reset_upd: got %b want 0", updated); end
    u0 = upd_cnt; dark_bad = 0; fs_cnt = 0; fs_first = -1; fs_last = -1; fs_gap_bad = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) dark_bad++;
      if (frame_start) begin
        if (fs_first < 0) fs_first = i;
        if (fs_last >= 0 && i - fs_last != 64) fs_gap_bad++;
        fs_last = i;
        fs_cnt++;
      end
    end
    tests++; if (dark_bad != 0) begin fails++; $display("FAIL noload_dark: got %0d lit samples want 0", dark_bad); end
    tests++; if (fs_first != 1) begin fails++; $display("FAIL fs_first: got cycle %0d want 1", fs_first); end
    tests++; if (fs_cnt != 4) begin fails++; $display("FAIL fs_count: got %0d want 4", fs_cnt); end
    tests++; if (fs_gap_bad != 0) begin fails++; $display("FAIL fs_period: got %0d bad gaps want 0", fs_gap_bad); end
    tests++; if (upd_cnt - u0 != 0) begin fails++; $display("FAIL noload_upd: got %0d pulses want 0", upd_cnt - u0); end
  endtask

  task automatic test_load();
    bit ok; int u0, bad, first; img_t im;
    brightness = 2'd3;
    do_reset();
    u0 = upd_cnt;
    repeat (4) @(negedge clk);
    do_load(16'h12AF, 4'b0010, 4'hF);
    exp_q.push_back('{dig: 16'h12AF, dp: 4'b0010, en: 4'hF});
    im = '0;
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL load_wait: got timeout want frame_start"); end
      if (f == 0 && exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL load_frame%0d: %0d bad, k=%0d got %h want %h", f, bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
    tests++; if (upd_cnt - u0 != 1) begin fails++; $display("FAIL load_upd: got %0d pulses want 1", upd_cnt - u0); end
  endtask

  task automatic test_back_to_back();
    bit ok; int u0, bad, first; img_t im;
    wait_frame(ok);
    if (!ok) begin tests++; fails++; $display("FAIL b2b_sync: got timeout want frame_start"); end
    u0 = upd_cnt;
    repeat (5) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'hF);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'hF);
    exp_q.push_back('{dig: 16'h2222, dp: 4'b0000, en: 4'hF});
    im = '0;
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL b2b_wait: got timeout want frame_start"); end
      if (f == 0 && exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL b2b_frame%0d: %0d bad, k=%0d got %h want %h", f, bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
    tests++; if (upd_cnt - u0 != 1) begin fails++; $display("FAIL b2b_upd: got %0d pulses want 1", upd_cnt - u0); end
  endtask

  task automatic test_boundary_load();
    bit ok; int u0, bad, first; img_t im;
    wait_frame(ok);
    if (!ok) begin tests++; fails++; $display("FAIL bnd_sync: got timeout want frame_start"); end
    u0 = upd_cnt;
    repeat (10) @(negedge clk);
    do_load(16'h7777, 4'b0000, 4'hF);   // pending, superseded at the boundary
    repeat (51) @(negedge clk);
    do_load(16'h3C5E, 4'b1001, 4'hF);   // load high across the boundary edge
    exp_q.push_back('{dig: 16'h3C5E, dp: 4'b1001, en: 4'hF});
    im = '0;
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL bnd_wait: got timeout want frame_start"); end
      if (f == 0 && exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL bnd_frame%0d: %0d bad, k=%0d got %h want %h", f, bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
    tests++; if (upd_cnt - u0 != 1) begin fails++; $display("FAIL bnd_upd: got %0d pulses want 1", upd_cnt - u0); end
  endtask

  task automatic test_brightness();
    bit ok; int bad, first; img_t im;
    logic [1:0] br_seq[3];
    logic [3:0] en_seq[3];
    br_seq = '{2'd0, 2'd1, 2'd3};
    en_seq = '{4'hF, 4'hF, 4'b0101};
    im = '0;
    for (int s = 0; s < 3; s++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL br_sync: got timeout want frame_start"); end
      repeat (3) @(negedge clk);
      brightness = br_seq[s];
      do_load(16'h3C5E, 4'b0000, en_seq[s]);
      exp_q.push_back('{dig: 16'h3C5E, dp: 4'b0000, en: en_seq[s]});
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL br_wait: got timeout want frame_start"); end
      if (exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL br_step%0d: %0d bad, k=%0d got %h want %h", s, bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
  endtask

  task automatic test_blank();
    bit ok; int bad, first; img_t im;
    logic [15:0] dseq[2];
    dseq = '{16'h0050, 16'h0000};
    brightness = 2'd3;
    im = '0;
    for (int s = 0; s < 2; s++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL blank_sync: got timeout want frame_start"); end
      repeat (3) @(negedge clk);
      do_load(dseq[s], 4'b0000, 4'hF);
      exp_q.push_back('{dig: dseq[s], dp: 4'b0000, en: 4'hF});
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL blank_wait: got timeout want frame_start"); end
      if (exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL blank_%h: %0d bad, k=%0d got %h want %h", dseq[s], bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int u0, bad, first; img_t im;
    wait_frame(ok);
    if (!ok) begin tests++; fails++; $display("FAIL rst_sync: got timeout want frame_start"); end
    repeat (3) @(negedge clk);
    do_load(16'h9876, 4'b0000, 4'hF);   // left pending, must be discarded
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++; $display("FAIL rst_mid_dark: got %h want %h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    @(negedge clk);
    reset = 1'b0;
    u0 = upd_cnt;
    exp_q.push_back('0);
    im = '0;
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL rst_wait: got timeout want frame_start"); end
      if (f == 0 && exp_q.size() > 0) im = exp_q.pop_front();
      capture_frame();
      bad = 0; first = 0;
      for (int k = 0; k < 64; k++)
        if (fbuf[k] !== expect_out(im, brightness, k)) begin if (bad == 0) first = k; bad++; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL rst_frame%0d: %0d bad, k=%0d got %h want %h", f, bad, first, fbuf[first],
                 expect_out(im, brightness, first));
      end
    end
    tests++; if (upd_cnt - u0 != 0) begin fails++; $display("FAIL rst_upd: got %0d pulses want 0", upd_cnt - u0); end
  endtask

  task automatic test_onehot();
    tests++;
    if (onehot_bad != 0) begin
      fails++; $display("FAIL an_onehot: got %0d multi-low samples want 0", onehot_bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    en_in = '0;
    brightness = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_brightness();
    test_blank();
    test_reset_mid();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sev_seg_scanner.md
Name: sev_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for common-anode displays. Supports N digits, per-digit enable and decimal point, and PWM brightness. Display data is double-buffered with a load strobe, so the visible image changes only at a frame boundary and never tears mid-scan. Sits between the datapath (ALU result / counter formatting) and the board's Seg/AN/DP pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
SLOT_LOG2, 17, log2 of clock cycles each digit is driven (slot length = 2^SLOT_LOG2)
BRIGHT_W, 4, brightness control width; must be <= SLOT_LOG2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits_in  in  4*NUM_DIGITS  hex value per digit; digit i = bits [4i+3:4i]; digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
en_in  in  NUM_DIGITS  digit enable per digit (1 = shown)
load  in  1  single-cycle strobe: capture digits_in/dp_in/en_in into pending buffer
brightness  in  BRIGHT_W  PWM duty; 0 = dark; sampled continuously
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  anodes, active-low, at most one low at any time
frame_start  out  1  one-cycle pulse when the scan returns to digit 0
updated  out  1  one-cycle pulse when the pending buffer is committed to the active buffer

Behaviour:
- Reset (async assert, sync-safe deassert): tick=0, idx=0, active/pending buffers all 0, pending_valid=0; an=all 1s, seg=7'h7F, dp=1, frame_start=0, updated=0.
- tick: SLOT_LOG2-bit free-running counter. At tick==all-ones, idx advances; it wraps from NUM_DIGITS-1 to 0. The wrap cycle is the frame boundary.
- load=1: pending <= inputs; pending_valid <= 1. A second load before the boundary overwrites pending; the latest load wins.
- Frame boundary with pending_valid=1 and load=0: active <= pending; pending_valid <= 0; updated=1 in the next cycle.
- Frame boundary with load=1: inputs bypass to active directly; pending_valid <= 0; updated=1.
- No load ever seen: active stays all-zero; all enables are 0, so the display stays dark.
- Hex decode 0-F, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- PWM: let top = tick[SLOT_LOG2-1 -: BRIGHT_W]. The digit is lit iff en[idx]=1 and top < brightness. Maximum duty is (2^BRIGHT_W-1)/2^BRIGHT_W.
- Lit digit: an[idx]=0, seg=decode(active digit idx), dp=~dp[idx].
- Unlit digit: an=all 1s, seg=7'h7F, dp=1.
- Latency: an/seg/dp/frame_start are registered, one cycle after the tick/idx state that produces them.
- frame_start is asserted in the cycle in which an first reflects idx=0.
- A brightness change takes effect on the next cycle's compare; no glitch beyond one cycle.
- Reset mid-frame: all outputs are dark on the next sample; pending data is discarded.

Optional Feature:
SEV_SEG_LEADING_ZERO_BLANK_EN:
- Defined: starting from digit NUM_DIGITS-1 downward, an enabled digit with value 0 and dp=0 is treated as disabled until the first digit that is nonzero or has dp set. Digit 0 is never blanked. Blanking is computed from the active buffer only.
- Undefined: zeros are displayed normally; no extra logic is present.

Test Plan:
(Bench uses NUM_DIGITS=4, SLOT_LOG2=4, BRIGHT_W=2.)
- Reset, then no load with brightness=3 -> an=4'hF, seg=7'h7F and dp=1 for 200 cycles; frame_start pulses every 64 cycles; updated never pulses.
- load digits=16'h12AF, dp=4'b0010, en=4'hF at cycle 5, brightness=3 -> updated pulses once after the first boundary. Per frame, an cycles E,D,B,7 with seg 0E,08,24,79, each lit for 12 of 16 cycles. dp is 0 only while an=4'hD.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 is ever displayed; updated pulses once.
- load coincident with the boundary cycle -> new data is shown from digit 0 of the frame that starts there; updated pulses once; no stale pending commit at the following boundary.
- brightness=0 -> an stays 4'hF. brightness=1 -> each enabled digit is lit for 4 of 16 cycles. en=4'b0101 -> an never drives digits 1 or 3 low.
- With SEV_SEG_LEADING_ZERO_BLANK_EN: digits=16'h0050 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0. digits=16'h0000 -> only digit 0 is shown. Without the macro, all four digits are shown.
